// File: rtl/uart_program_loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} loaderState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rxState_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/frame-error pulses.
// Latency: byteValid/frameErr one cycle after the stop-bit sample.
// Backpressure: none; bytes are pulsed out and must be consumed on the spot.
module uart_rx_core
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byteValid,
    output logic [7:0] dataByte,
    output logic       frameErr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxMeta, rxSync, rxLast;
    rxState_t         state, stateNext;
    logic [CNT_W-1:0] baudCnt, cntNext;
    logic [2:0]       bitIdx, bitNext;
    logic [7:0]       shiftReg, shiftNext, byteNext;
    logic             validNext, errNext;

    always_comb begin
        stateNext = state;
        cntNext   = baudCnt + 1'b1;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        byteNext  = dataByte;
        validNext = 1'b0;
        errNext   = 1'b0;
        case (state)
            RX_IDLE: begin
                cntNext = '0;
                if (rxLast && !rxSync) stateNext = RX_START;
            end
            RX_START: if (baudCnt == HALF_M1) begin
                // A start bit that is high again at mid-bit was only a glitch.
                cntNext   = '0;
                bitNext   = '0;
                stateNext = rxSync ? RX_IDLE : RX_BITS;
            end
            RX_BITS: if (baudCnt == FULL_M1) begin
                cntNext   = '0;
                shiftNext = {rxSync, shiftReg[7:1]};
                bitNext   = bitIdx + 3'd1;
                if (bitIdx == 3'd7) stateNext = RX_STOP;
            end
            RX_STOP: if (baudCnt == FULL_M1) begin
                cntNext   = '0;
                stateNext = RX_IDLE;
                if (rxSync) begin
                    validNext = 1'b1;
                    byteNext  = shiftReg;
                end else begin
                    errNext = 1'b1;
                end
            end
            default: stateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxLast    <= 1'b1;
            state     <= RX_IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            dataByte  <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxSync    <= rxMeta;
            rxLast    <= rxSync;
            state     <= stateNext;
            baudCnt   <= cntNext;
            bitIdx    <= bitNext;
            shiftReg  <= shiftNext;
            dataByte  <= byteNext;
            byteValid <= validNext;
            frameErr  <= errNext;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program over UART, writes words to program memory, then releases the CPU.
// Latency: 4th byte -> mem_we 1 cycle; last mem_we -> cpu_run 1 cycle.
// Backpressure: none; memory accepts every write strobe unconditionally.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEMORY_DEPTH = 32,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(MEMORY_DEPTH);

    logic             byteValid, frameErr;
    logic [7:0]       dataByte;
    loaderState_t     state, stateNext;
    logic [7:0]       nLow;
    logic [LEN_W-1:0] nFull;
    logic [ADDR_WIDTH:0] nCount;
    logic [1:0]       byteIdx;
    logic [23:0]      wordBuf;
    logic             takeByte;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxCore (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byteValid (byteValid),
        .dataByte  (dataByte),
        .frameErr  (frameErr)
    );

    assign nFull    = {dataByte, nLow};
    assign takeByte = byteValid && !frameErr;

    assign cpu_run = (state == DONE);
    assign busy    = (state == LEN1) || (state == DATA);
    assign error   = (state == ERR);

    always_comb begin
        stateNext = state;
        case (state)
            LEN0: if (frameErr) stateNext = ERR;
                  else if (byteValid) stateNext = LEN1;
            LEN1: if (frameErr) stateNext = ERR;
                  else if (byteValid) begin
                      if (nFull > MAX_WORDS)  stateNext = ERR;
                      else if (nFull == '0)   stateNext = DONE;
                      else                    stateNext = DATA;
                  end
            // words_loaded has already advanced during the final write strobe.
            DATA: if (frameErr) stateNext = ERR;
                  else if (mem_we && words_loaded == nCount) stateNext = DONE;
            DONE:    stateNext = DONE;
            ERR:     stateNext = ERR;
            default: stateNext = LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LEN0;
            nLow         <= '0;
            nCount       <= '0;
            byteIdx      <= '0;
            wordBuf      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            state  <= stateNext;
            mem_we <= 1'b0;
            if (state == LEN0 && takeByte) nLow <= dataByte;
            if (state == LEN1 && takeByte) begin
                nCount  <= nFull[ADDR_WIDTH:0];
                byteIdx <= '0;
            end
            if (state == DATA && takeByte) begin
                byteIdx <= byteIdx + 2'd1;
                case (byteIdx)
                    2'd0: wordBuf[7:0]   <= dataByte;
                    2'd1: wordBuf[15:8]  <= dataByte;
                    2'd2: wordBuf[23:16] <= dataByte;
                    default: ;
                endcase
                if (byteIdx == 2'(BYTES_PER_WORD - 1)) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                    mem_wdata    <= {dataByte, wordBuf};
                    words_loaded <= words_loaded + 1'b1;
                end
            end
        end
    end

endmodule
